// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch run controller: FSM state codes,
// state width and the helpers that derive the prescaler divide ratio and
// the debounce window length from the clock parameters.
package sw_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_LAP   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_CLR   = 3'd4
   } sw_state_e;

   localparam int DEF_CLK_HZ  = 125_000_000;
   localparam int DEF_TICK_HZ = 100;

   // Clocks per tick period; must come out even and at least 2.
   function automatic int sw_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   localparam int DEF_DIV = sw_div(DEF_CLK_HZ, DEF_TICK_HZ);

   // Number of clocks a button level must hold before it is accepted.
   function automatic int sw_db_cycles(input int clk_hz, input int db_ms);
      longint prod;
      prod = longint'(db_ms) * longint'(clk_hz) / 64'sd1000;
      return (prod < 1) ? 1 : int'(prod);
   endfunction

endpackage

// File: rtl/sw_btn_edge.sv
// Button front end: two-flop synchroniser, optional stability filter
// (enabled by the SW_DEBOUNCE_EN macro) and a registered one-cycle strobe
// on each accepted rising edge of the button level.
module sw_btn_edge
   import sw_pkg::*;
#(
   parameter int DB_CYC = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic sync1;
   logic sync2;
   logic level;
   logic level_d;

   // Bring the raw pin into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef SW_DEBOUNCE_EN
   localparam int DB_N  = (DB_CYC < 1) ? 1 : DB_CYC;
   localparam int DBC_W = (DB_N < 2) ? 1 : $clog2(DB_N + 1);

   logic [DBC_W-1:0] db_cnt;
   logic             db_level;

   // Accept a new level only once it has differed from the accepted level
   // for DB_N consecutive clocks; any return to the old level restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
      end else if (sync2 == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DBC_W'(DB_N - 1)) begin
         db_level <= sync2;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign level = db_level;
`else
   assign level = sync2;
`endif

   // Registered rising-edge detect so the strobe is exactly one clock wide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/sw_run_ctrl.sv
// Stopwatch run controller: turns start/stop and lap/clear presses into
// run/pause/lap/clear sequencing for the counter chain and produces the
// half-duty centisecond tick. Define SW_DEBOUNCE_EN to add an on-chip
// stability filter to both buttons.
module sw_run_ctrl
   import sw_pkg::*;
#(
   parameter int CLK_HZ  = DEF_CLK_HZ,
   parameter int TICK_HZ = DEF_TICK_HZ,
   parameter int DB_MS   = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_ss,
   input  logic            btn_lc,
   output logic            tick_out,
   output logic            cnt_en,
   output logic            cnt_clr,
   output logic            disp_freeze,
   output logic            run_led,
   output logic [ST_W-1:0] state
);

   localparam int DIV    = sw_div(CLK_HZ, TICK_HZ);
   localparam int DIV_W  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int HALF   = DIV / 2;
   localparam int DB_CYC = sw_db_cycles(CLK_HZ, DB_MS);

   logic             ss_p;
   logic             lc_p;
   sw_state_e        state_q;
   sw_state_e        state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;

   sw_btn_edge #(.DB_CYC(DB_CYC)) u_ss (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_ss),
      .press (ss_p)
   );

   sw_btn_edge #(.DB_CYC(DB_CYC)) u_lc (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_lc),
      .press (lc_p)
   );

   // Next-state decode; start/stop is checked first so it wins a tie.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ss_p)      state_nxt = ST_RUN;
            else if (lc_p) state_nxt = ST_CLR;
         end
         ST_RUN: begin
            if (ss_p)      state_nxt = ST_PAUSE;
            else if (lc_p) state_nxt = ST_LAP;
         end
         ST_LAP: begin
            if (ss_p)      state_nxt = ST_PAUSE;
            else if (lc_p) state_nxt = ST_RUN;
         end
         ST_PAUSE: begin
            if (ss_p)      state_nxt = ST_RUN;
            else if (lc_p) state_nxt = ST_CLR;
         end
         ST_CLR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register plus outputs decoded from the next state, so outputs
   // move on the same edge as the state itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_en      <= 1'b0;
         cnt_clr     <= 1'b0;
         disp_freeze <= 1'b0;
         run_led     <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cnt_en      <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
         cnt_clr     <= (state_nxt == ST_CLR);
         disp_freeze <= (state_nxt == ST_LAP);
         run_led     <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
      end
   end

   assign state   = state_q;
   assign div_nxt = (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;

   // Prescaler: counts only while enabled so pause/lap keep the partial
   // period; clearing happens while cnt_en is already low so the counter
   // chain ignores any falling edge it creates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         tick_out <= 1'b0;
      end else if (state_nxt == ST_CLR) begin
         div_cnt  <= '0;
         tick_out <= 1'b0;
      end else if (cnt_en) begin
         div_cnt  <= div_nxt;
         tick_out <= (div_nxt >= DIV_W'(HALF));
      end
   end

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Self-checking bench for sw_run_ctrl (CLK_HZ=1000, TICK_HZ=100 -> DIV=10,
// DB_MS=2 -> 2-clock debounce window when SW_DEBOUNCE_EN is defined).
module tb_sw_run_ctrl;

`ifdef SW_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 4;
`endif

   logic       clk;
   logic       rst;
   logic       btn_ss;
   logic       btn_lc;
   logic       tick_out;
   logic       cnt_en;
   logic       cnt_clr;
   logic       disp_freeze;
   logic       run_led;
   logic [2:0] state;

   int vectors;
   int miscompares;

   logic [6:0] exp_q[$];
   string      tag_q[$];

   sw_run_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_MS(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_ss      (btn_ss),
      .btn_lc      (btn_lc),
      .tick_out    (tick_out),
      .cnt_en      (cnt_en),
      .cnt_clr     (cnt_clr),
      .disp_freeze (disp_freeze),
      .run_led     (run_led),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] outVec();
      return {state, cnt_en, cnt_clr, disp_freeze, run_led};
   endfunction

   function automatic logic [6:0] mk(input logic [2:0] st, input logic en,
                                     input logic clr, input logic frz);
      return {st, en, clr, frz, en};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // Press the chosen button(s), wait (bounded) for the state to move, then
   // check latency and the scoreboard's expected output vector.
   task automatic applyStimulus(input bit ss, input bit lc, input string tag,
                                input logic [6:0] exp);
      logic [2:0] start;
      int         cyc;
      logic [6:0] want;
      string      wtag;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      start  = state;
      btn_ss = ss;
      btn_lc = lc;
      cyc    = 0;
      while (state === start && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      btn_ss = 1'b0;
      btn_lc = 1'b0;
      checkOutput({tag, "_lat"}, cyc, LAT);
      want = exp_q.pop_front();
      wtag = tag_q.pop_front();
      checkOutput(wtag, {25'd0, outVec()}, {25'd0, want});
   endtask

   initial begin
      int cyc;
      int clr_seen;
      vectors     = 0;
      miscompares = 0;
      btn_ss      = 1'b0;
      btn_lc      = 1'b0;
      rst         = 1'b0;
      #2 rst      = 1'b1;
      idle(3);
      checkOutput("reset_state", {24'd0, tick_out, outVec()}, 32'd0);
      rst = 1'b0;
      idle(3);

      // IDLE -> RUN, then the tick waveform from a fresh prescaler
      applyStimulus(1'b1, 1'b0, "idle_ss_run", mk(3'd1, 1'b1, 1'b0, 1'b0));
      for (int k = 0; k < 24; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         checkOutput($sformatf("tick_k%0d", k), {31'd0, tick_out},
                     {31'd0, ((k % 10) >= 5) ? 1'b1 : 1'b0});
      end

      // Pause with prescaler landing on 7: tick held high
      applyStimulus(1'b1, 1'b0, "run_ss_pause", mk(3'd3, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++) begin
         checkOutput("pause_tick_hold", {31'd0, tick_out}, 32'd1);
         @(posedge clk);
         #1;
      end

      // Resume: partial period continues, first fall 3 cycles later
      applyStimulus(1'b1, 1'b0, "pause_ss_run", mk(3'd1, 1'b1, 1'b0, 1'b0));
      checkOutput("resume_tick_high", {31'd0, tick_out}, 32'd1);
      cyc = 0;
      while (tick_out === 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput("resume_first_fall", cyc, 32'd3);
      idle(8);

      // Lap sequencing
      applyStimulus(1'b0, 1'b1, "run_lc_lap", mk(3'd2, 1'b1, 1'b0, 1'b1));
      idle(8);
      applyStimulus(1'b0, 1'b1, "lap_lc_run", mk(3'd1, 1'b1, 1'b0, 1'b0));
      idle(8);
      applyStimulus(1'b0, 1'b1, "run_lc_lap2", mk(3'd2, 1'b1, 1'b0, 1'b1));
      idle(8);
      applyStimulus(1'b1, 1'b0, "lap_ss_pause", mk(3'd3, 1'b0, 1'b0, 1'b0));
      idle(8);

      // Clear from PAUSE: one-cycle clr with counting stopped
      applyStimulus(1'b0, 1'b1, "pause_lc_clr", mk(3'd4, 1'b0, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      checkOutput("clr_to_idle", {24'd0, tick_out, outVec()}, 32'd0);
      idle(8);

      // Clear straight from IDLE
      applyStimulus(1'b0, 1'b1, "idle_lc_clr", mk(3'd4, 1'b0, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      checkOutput("idle_clr_back", {25'd0, outVec()}, 32'd0);
      idle(8);

      // Simultaneous presses in RUN: start/stop wins
      applyStimulus(1'b1, 1'b0, "idle_ss_run2", mk(3'd1, 1'b1, 1'b0, 1'b0));
      idle(8);
      applyStimulus(1'b1, 1'b1, "both_run_pause", mk(3'd3, 1'b0, 1'b0, 1'b0));
      idle(10);
      checkOutput("both_no_lap", {25'd0, outVec()}, {25'd0, mk(3'd3, 1'b0, 1'b0, 1'b0)});

`ifdef SW_DEBOUNCE_EN
      // Single-clock glitch must be filtered out
      btn_ss = 1'b1;
      @(posedge clk);
      #1;
      btn_ss = 1'b0;
      idle(12);
      checkOutput("glitch_ignored", {29'd0, state}, 32'd3);
`endif

      // Asynchronous reset in the middle of a run
      applyStimulus(1'b1, 1'b0, "pause_ss_run2", mk(3'd1, 1'b1, 1'b0, 1'b0));
      idle(3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst", {24'd0, tick_out, outVec()}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      clr_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (cnt_clr === 1'b1) clr_seen++;
      end
      checkOutput("rst_no_clr", clr_seen, 32'd0);
      checkOutput("rst_idle", {24'd0, tick_out, outVec()}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
